bus_dma_master: RTL and testbench
=================================

Name: bus_dma_master

Overview:
- Bus-master counterpart on the 8088 minimum-mode system bus.
- Requests the bus from the CPU via HOLD/HLDA, then initiates 8088-style T1–T4 read and write cycles toward the memory/IO responders through the shared address latch and data transceiver.
- Performs COUNT byte transfers: each transfer is a read from a source followed by a write to a destination.
- Releases the bus when finished, then signals DONE.

Parameters:
- CNT_W, 16, width of transfer count.
- MAX_WAIT, 15, maximum consecutive Tw states tolerated per cycle before abort.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle start request, sampled only in IDLE.
- SRC_ADDR  in  20  source start address, captured on accepted START.
- DST_ADDR  in  20  destination start address, captured on accepted START.
- SRC_IOM  in  1  source space: 1 = I/O, 0 = memory.
- DST_IOM  in  1  destination space: 1 = I/O, 0 = memory.
- SRC_INC  in  1  increment source address after each transfer.
- DST_INC  in  1  increment destination address after each transfer.
- COUNT  in  CNT_W  number of bytes, captured on START.
- HOLD  out  1  bus request to CPU.
- HLDA  in  1  bus grant from CPU.
- BUS_OE  out  1  master owns the bus; gates ADDR/IOM/ALE/RD_N/WR_N onto the bus.
- ADDR  out  20  bus address.
- IOM  out  1  cycle type: 1 = I/O, 0 = memory.
- ALE  out  1  address latch enable.
- RD_N  out  1  read strobe, active low.
- WR_N  out  1  write strobe, active low.
- DATA_OUT  out  8  write data.
- DATA_OE  out  1  drive DATA_OUT onto the data bus.
- DATA_IN  in  8  read data from the data bus.
- READY  in  1  responder ready; low inserts wait states.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky wait-timeout flag; cleared by the next accepted START.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - Low: HOLD, BUS_OE, ALE, DATA_OE, BUSY, DONE, ERR, IOM.
  - High: RD_N, WR_N.
  - ADDR=0, DATA_OUT=0, state=IDLE.
  - Reset during any state releases HOLD immediately.
- States: IDLE, REQ, T1, T2, T3, TW, T4, REL, FIN. A phase bit (RDPH/WRPH) selects read or write.
- IDLE:
  - START=1 with COUNT≠0: capture inputs, clear ERR, BUSY=1, HOLD=1, go to REQ.
  - START=1 with COUNT=0: DONE=1 for one cycle, no bus request, remain IDLE.
  - START outside IDLE is ignored.
- REQ: hold HOLD=1; when HLDA=1 is sampled, go to T1 in RDPH.
- T1: BUS_OE=1, ALE=1, RD_N=WR_N=1.
  - ADDR = current src (RDPH) or dst (WRPH).
  - IOM = SRC_IOM or DST_IOM respectively.
  - For I/O cycles, ADDR[19:16]=0.
- T2: ALE=0, address held.
  - RDPH: RD_N=0.
  - WRPH: WR_N=0, DATA_OE=1, DATA_OUT = holding register.
- T3: strobe held.
  - READY=1: go to T4.
  - READY=0: go to TW, wait counter=1.
- TW: strobe held.
  - READY=1: go to T4.
  - Otherwise wait counter increments.
  - Wait counter reaching MAX_WAIT with READY still 0: abort. Strobes go high, DATA_OE=0, ERR=1, go to REL.
- Read data: holding register latches DATA_IN on the edge leaving T3 or TW with READY=1 in RDPH.
- T4: RD_N=WR_N=1; DATA_OE stays 1 through T4 in WRPH and is 0 afterwards.
  - After RDPH: T1 in WRPH.
  - After WRPH: count decrements; src/dst increment (mod 2^20) if the respective INC bit is set. Then count=0 goes to REL; otherwise T1 in RDPH.
- REL: BUS_OE=0, HOLD=0. Wait for HLDA=0, then FIN.
- FIN: DONE=1 for one cycle, BUSY=0, return to IDLE.
- Timing:
  - Zero-wait transfer = 8 clocks (read T1–T4 + write T1–T4).
  - Each Tw adds 1 clock.
  - Overhead: 1 REQ cycle minimum + REL + FIN.
- HLDA is sampled only in REQ and REL; HLDA deassertion during T-states is a CPU protocol violation and is ignored.
- Count wraps never occur: the transfer terminates at 0. An address increment from 20'hFFFFF wraps to 20'h00000.

Test Plan:
- COUNT=1, SRC=20'h00010 mem, DST=16'h0040 I/O, HLDA one cycle after HOLD, READY=1 -> HOLD high; one ALE with ADDR=20'h00010, IOM=0, RD_N low 2 cycles; then ALE with ADDR=20'h00040, IOM=1, WR_N low 2 cycles, DATA_OUT = byte read; DONE after HLDA falls; 8 T-state clocks total.
- COUNT=4, both INC=1, SRC=20'h7FFFE -> source addresses 7FFFE, 7FFFF, 80000, 80001; four read/write pairs; BUSY high throughout.
- READY held low 3 cycles in the first read T3 -> exactly 3 TW states, data latched on READY=1, transfer = 11 clocks.
- READY held low with MAX_WAIT=15 -> abort after 15 TW; strobes released, ERR=1, HOLD drops, DONE pulses, ERR stays set until the next START.
- START with COUNT=0 -> DONE one cycle later, HOLD never asserted. START while BUSY -> ignored, captured values unchanged.
- RESET_N pulsed low during a write T2 -> HOLD, BUS_OE, DATA_OE, BUSY immediately 0, WR_N=1; state IDLE after release.

Source files
------------

// File: rtl/bus_dma_master.sv
// bus_dma_master: 8088 minimum-mode bus master.
// Requests the bus with HOLD/HLDA, then moves COUNT bytes by running a
// T1-T4 read cycle from the source followed by a T1-T4 write cycle to the
// destination for every byte. When the count runs out, or a responder stalls
// for too long, it releases the bus and pulses DONE.
module bus_dma_master #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [19:0]      SRC_ADDR,
  input  logic [19:0]      DST_ADDR,
  input  logic             SRC_IOM,
  input  logic             DST_IOM,
  input  logic             SRC_INC,
  input  logic             DST_INC,
  input  logic [CNT_W-1:0] COUNT,
  output logic             HOLD,
  input  logic             HLDA,
  output logic             BUS_OE,
  output logic [19:0]      ADDR,
  output logic             IOM,
  output logic             ALE,
  output logic             RD_N,
  output logic             WR_N,
  output logic [7:0]       DATA_OUT,
  output logic             DATA_OE,
  input  logic [7:0]       DATA_IN,
  input  logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4,
    S_REL,
    S_FIN
  } state_t;

  state_t            state;
  logic              wr_ph;      // 0 = read phase, 1 = write phase
  logic [WAIT_W-1:0] wait_cnt;

  // Transfer context captured at START and advanced after every write.
  logic [19:0]       src;
  logic [19:0]       dst;
  logic [CNT_W-1:0]  cnt;
  logic              src_iom;
  logic              dst_iom;
  logic              src_inc;
  logic              dst_inc;
  logic [7:0]        hold_byte;

  logic [19:0]       src_nxt;

  // I/O space only decodes 16 address bits; the upper nibble is driven low.
  function automatic logic [19:0] bus_addr(input logic [19:0] a, input logic iom);
    return iom ? {4'h0, a[15:0]} : a;
  endfunction

  // Source address the next read cycle will use once the current write completes.
  always_comb begin
    src_nxt = src_inc ? src + 20'd1 : src;
  end

  // Transfer context: capture on accepted START, step after each write T4,
  // and latch read data when the read cycle leaves T3/TW with READY.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && START && COUNT != '0) begin
      src     <= SRC_ADDR;
      dst     <= DST_ADDR;
      cnt     <= COUNT;
      src_iom <= SRC_IOM;
      dst_iom <= DST_IOM;
      src_inc <= SRC_INC;
      dst_inc <= DST_INC;
    end else if (state == S_T4 && wr_ph) begin
      cnt <= cnt - CNT_W'(1);
      src <= src_nxt;
      dst <= dst_inc ? dst + 20'd1 : dst;
    end
    if ((state == S_T3 || state == S_TW) && READY && !wr_ph) begin
      hold_byte <= DATA_IN;
    end
  end

  // Bus-cycle sequencer; every bus-facing output is registered here.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      wr_ph    <= 1'b0;
      wait_cnt <= '0;
      HOLD     <= 1'b0;
      BUS_OE   <= 1'b0;
      ADDR     <= 20'h00000;
      IOM      <= 1'b0;
      ALE      <= 1'b0;
      RD_N     <= 1'b1;
      WR_N     <= 1'b1;
      DATA_OUT <= 8'h00;
      DATA_OE  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            if (COUNT != '0) begin
              ERR   <= 1'b0;
              BUSY  <= 1'b1;
              HOLD  <= 1'b1;
              state <= S_REQ;
            end else begin
              // Nothing to move: acknowledge without touching the bus.
              DONE <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (HLDA) begin
            state  <= S_T1;
            wr_ph  <= 1'b0;
            BUS_OE <= 1'b1;
            ALE    <= 1'b1;
            ADDR   <= bus_addr(src, src_iom);
            IOM    <= src_iom;
          end
        end

        S_T1: begin
          ALE   <= 1'b0;
          state <= S_T2;
          if (wr_ph) begin
            WR_N     <= 1'b0;
            DATA_OE  <= 1'b1;
            DATA_OUT <= hold_byte;
          end else begin
            RD_N <= 1'b0;
          end
        end

        S_T2: begin
          state <= S_T3;
        end

        S_T3: begin
          if (READY) begin
            state <= S_T4;
            RD_N  <= 1'b1;
            WR_N  <= 1'b1;
          end else begin
            state    <= S_TW;
            wait_cnt <= WAIT_W'(1);
          end
        end

        S_TW: begin
          if (READY) begin
            state <= S_T4;
            RD_N  <= 1'b1;
            WR_N  <= 1'b1;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            // Responder is stuck: drop the strobes and give the bus back.
            RD_N    <= 1'b1;
            WR_N    <= 1'b1;
            DATA_OE <= 1'b0;
            ERR     <= 1'b1;
            BUS_OE  <= 1'b0;
            HOLD    <= 1'b0;
            state   <= S_REL;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_T4: begin
          // Write data stays on the bus through T4 and is withdrawn here.
          DATA_OE <= 1'b0;
          if (!wr_ph) begin
            wr_ph <= 1'b1;
            state <= S_T1;
            ALE   <= 1'b1;
            ADDR  <= bus_addr(dst, dst_iom);
            IOM   <= dst_iom;
          end else if (cnt == CNT_W'(1)) begin
            state  <= S_REL;
            BUS_OE <= 1'b0;
            HOLD   <= 1'b0;
          end else begin
            wr_ph <= 1'b0;
            state <= S_T1;
            ALE   <= 1'b1;
            ADDR  <= bus_addr(src_nxt, src_iom);
            IOM   <= src_iom;
          end
        end

        S_REL: begin
          if (!HLDA) begin
            state <= S_FIN;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// tb_bus_dma_master: randomized scoreboard bench for bus_dma_master.
// Stimulus computes the expected list of bus cycles and completion results
// from the transfer rules; a monitor pops and compares as the DUT runs them.
module tb_bus_dma_master;

  localparam int CNT_W    = 16;
  localparam int MAX_WAIT = 15;

  logic             CLK;
  logic             RESET_N;
  logic             START;
  logic [19:0]      SRC_ADDR;
  logic [19:0]      DST_ADDR;
  logic             SRC_IOM;
  logic             DST_IOM;
  logic             SRC_INC;
  logic             DST_INC;
  logic [CNT_W-1:0] COUNT;
  logic             HOLD;
  logic             HLDA;
  logic             BUS_OE;
  logic [19:0]      ADDR;
  logic             IOM;
  logic             ALE;
  logic             RD_N;
  logic             WR_N;
  logic [7:0]       DATA_OUT;
  logic             DATA_OE;
  logic [7:0]       DATA_IN;
  logic             READY;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  bus_dma_master #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR),
    .SRC_IOM(SRC_IOM), .DST_IOM(DST_IOM),
    .SRC_INC(SRC_INC), .DST_INC(DST_INC), .COUNT(COUNT),
    .HOLD(HOLD), .HLDA(HLDA), .BUS_OE(BUS_OE), .ADDR(ADDR), .IOM(IOM),
    .ALE(ALE), .RD_N(RD_N), .WR_N(WR_N), .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE), .DATA_IN(DATA_IN), .READY(READY),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    bit          iom;
    logic [8:0]  data;   // {DATA_OE, DATA_OUT} during the strobe
    int          len;    // strobe-low clocks
  } cyc_t;

  typedef struct {
    bit err;
    int tclk;            // clocks with BUS_OE high
  } done_t;

  cyc_t  exp_q[$];
  done_t done_q[$];
  int    wait_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    err_model = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Bus address as the responder sees it: I/O space ignores the top nibble.
  function automatic logic [19:0] eaddr(input logic [19:0] a, input bit iom);
    return iom ? {4'h0, a[15:0]} : a;
  endfunction

  // Responder contents: a fixed function of the bus address and space.
  function automatic logic [7:0] rdata(input logic [19:0] a, input bit iom);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ (iom ? 8'hA5 : 8'h3C);
  endfunction

  // CPU: follows HOLD with HLDA after a random 0..2 extra clocks.
  int hdly = 0;
  initial begin
    HLDA = 1'b0;
    forever begin
      @(negedge CLK);
      if (HOLD !== HLDA) begin
        if (hdly == 0) begin
          HLDA = HOLD;
          hdly = $urandom_range(0, 2);
        end else begin
          hdly--;
        end
      end
    end
  end

  // Responder: drives read data and holds READY low for the scheduled waits.
  logic [19:0] r_addr;
  bit          r_iom;
  int          r_w;
  int          r_k;
  initial begin
    READY   = 1'b1;
    DATA_IN = 8'h00;
    r_addr  = '0;
    r_iom   = 1'b0;
    r_w     = 0;
    r_k     = 0;
    forever begin
      @(negedge CLK);
      if (ALE) begin
        r_addr = ADDR;
        r_iom  = IOM;
        r_w    = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        r_k    = 0;
      end
      if (!RD_N || !WR_N) begin
        r_k++;
        READY   = (r_k >= 2 + r_w);
        DATA_IN = rdata(r_addr, r_iom);
      end else begin
        READY = 1'b1;
      end
    end
  end

  // Monitor: reconstructs each bus cycle and each completion, then scores them.
  bit          act;
  logic [19:0] m_addr;
  bit          m_iom;
  bit          m_wr;
  logic [8:0]  m_data;
  int          slen;
  int          oe_cnt;
  bit          busy_bad;
  cyc_t        me;
  done_t       md;
  initial begin
    act = 1'b0; oe_cnt = 0; busy_bad = 1'b0; slen = 0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        act = 1'b0; oe_cnt = 0; busy_bad = 1'b0;
      end else begin
        if (BUS_OE) begin
          oe_cnt++;
          if (!BUSY) busy_bad = 1'b1;
        end
        if (ALE) begin
          act = 1'b1; m_addr = ADDR; m_iom = IOM; m_wr = 1'b0; m_data = '0; slen = 0;
        end else if (act) begin
          if (!RD_N || !WR_N) begin
            slen++;
            if (!WR_N) begin
              m_wr = 1'b1; m_data = {DATA_OE, DATA_OUT};
            end else begin
              m_data = {DATA_OE, 8'h00};
            end
          end else if (slen > 0) begin
            act = 1'b0;
            if (exp_q.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL cyc_extra: actual=cycle at %05h required=no cycle", m_addr);
            end else begin
              me = exp_q.pop_front();
              chk("cyc_wr",   32'(m_wr),   32'(me.wr));
              chk("cyc_addr", 32'(m_addr), 32'(me.addr));
              chk("cyc_iom",  32'(m_iom),  32'(me.iom));
              chk("cyc_data", 32'(m_data), 32'(me.data));
              chk("cyc_len",  32'(slen),   32'(me.len));
            end
          end
        end
        if (DONE) begin
          if (done_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL done_extra: actual=DONE pulse required=no pulse");
          end else begin
            md = done_q.pop_front();
            chk("done_err",   32'(ERR),      32'(md.err));
            chk("done_tclk",  32'(oe_cnt),   32'(md.tclk));
            chk("done_busy",  32'(BUSY),     32'(0));
            chk("busy_during_bus", 32'(busy_bad), 32'(0));
          end
          oe_cnt = 0; busy_bad = 1'b0;
        end
      end
    end
  end

  // Reference model + START. wmode: 0 no waits, 1 random 0..3 waits,
  // 2 three waits on the first read, 3 first read never becomes ready.
  task automatic run_job(input logic [19:0] s, input logic [19:0] d,
                         input bit siom, input bit diom, input bit sinc, input bit dinc,
                         input int cnt, input int wmode);
    cyc_t        c;
    done_t       de;
    int          tclk;
    bit          ab;
    logic [19:0] sa;
    logic [19:0] da;
    int          rw;
    int          ww;
    tclk = 0;
    ab   = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      sa = s + 20'(i * int'(sinc));
      da = d + 20'(i * int'(dinc));
      case (wmode)
        1:       rw = $urandom_range(0, 3);
        2:       rw = (i == 0) ? 3 : 0;
        3:       rw = (i == 0) ? MAX_WAIT + 5 : 0;
        default: rw = 0;
      endcase
      ww = (wmode == 1) ? $urandom_range(0, 3) : 0;
      wait_q.push_back(rw);
      c.wr = 1'b0; c.addr = eaddr(sa, siom); c.iom = siom; c.data = 9'h000;
      if (rw >= MAX_WAIT) begin
        c.len = 2 + MAX_WAIT;
        exp_q.push_back(c);
        tclk += 3 + MAX_WAIT;
        ab = 1'b1;
        break;
      end
      c.len = 2 + rw;
      exp_q.push_back(c);
      tclk += 4 + rw;
      wait_q.push_back(ww);
      c.wr = 1'b1; c.addr = eaddr(da, diom); c.iom = diom;
      c.data = {1'b1, rdata(eaddr(sa, siom), siom)};
      c.len = 2 + ww;
      exp_q.push_back(c);
      tclk += 4 + ww;
    end
    if (cnt > 0) err_model = ab;
    de.err  = err_model;
    de.tclk = tclk;
    done_q.push_back(de);
    @(negedge CLK);
    SRC_ADDR = s; DST_ADDR = d; SRC_IOM = siom; DST_IOM = diom;
    SRC_INC = sinc; DST_INC = dinc; COUNT = CNT_W'(cnt);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (DONE !== 1'b1 && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    chk({nm, "_done_seen"}, 32'(DONE), 32'(1));
    @(negedge CLK);
  endtask

  bit hold_seen;
  int kk;
  initial begin
    RESET_N = 1'b0; START = 1'b0; SRC_ADDR = '0; DST_ADDR = '0;
    SRC_IOM = 1'b0; DST_IOM = 1'b0; SRC_INC = 1'b0; DST_INC = 1'b0; COUNT = '0;
    repeat (3) @(negedge CLK);
    chk("rst_hold",  32'(HOLD),    32'(0));
    chk("rst_busoe", 32'(BUS_OE),  32'(0));
    chk("rst_strb",  32'({RD_N, WR_N, ALE, DATA_OE}), 32'(4'b1100));
    chk("rst_flags", 32'({BUSY, DONE, ERR, IOM}),     32'(0));
    chk("rst_addr",  32'(ADDR),    32'(0));
    chk("rst_dout",  32'(DATA_OUT), 32'(0));
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Single byte, memory to I/O, no waits: 8 T-state clocks.
    run_job(20'h00010, 20'h00040, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0);
    wait_done("single");

    // Four bytes across a 64K boundary, with a START poked while busy.
    run_job(20'h7FFFE, 20'h01000, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0);
    repeat (3) @(negedge CLK);
    chk("busy_mid", 32'(BUSY), 32'(1));
    SRC_ADDR = 20'h12345; DST_ADDR = 20'h54321; COUNT = CNT_W'(9); START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done("quad");

    // Three wait states on the first read: 11 clocks.
    run_job(20'h00123, 20'h00456, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2);
    wait_done("waits3");

    // Stuck responder: abort after MAX_WAIT waits, ERR sticky.
    run_job(20'h00200, 20'h00300, 1'b0, 1'b0, 1'b1, 1'b1, 2, 3);
    wait_done("abort");
    repeat (5) @(negedge CLK);
    chk("err_sticky", 32'(ERR), 32'(1));

    // Zero count: DONE one clock later, no bus request, ERR untouched.
    run_job(20'h00000, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("zero_done_lat", 32'(DONE), 32'(1));
    hold_seen = HOLD;
    repeat (4) begin
      @(negedge CLK);
      hold_seen |= HOLD;
    end
    chk("zero_no_hold", 32'(hold_seen), 32'(0));
    chk("zero_err_kept", 32'(ERR), 32'(1));

    // Next real START clears ERR.
    run_job(20'h00500, 20'h00600, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1);
    chk("err_cleared", 32'(ERR),  32'(0));
    chk("start_busy",  32'(BUSY), 32'(1));
    chk("start_hold",  32'(HOLD), 32'(1));
    wait_done("after_abort");

    // 20-bit wrap in memory space, and I/O with nonzero upper bits.
    run_job(20'hFFFFE, 20'h20000, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1);
    wait_done("wrap_mem");
    run_job(20'hABCDE, 20'h5FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1);
    wait_done("io_mask");

    // Randomized transfers.
    for (int j = 0; j < 10; j++) begin
      run_job(20'($urandom), 20'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(1, 5), 1);
      wait_done("rand");
    end

    // Asynchronous reset in the middle of a write T2.
    run_job(20'h00A00, 20'h00B00, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0);
    kk = 0;
    while (WR_N !== 1'b0 && kk < 500) begin
      @(negedge CLK);
      kk++;
    end
    chk("rst_reach_wr", 32'(WR_N), 32'(0));
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_hold",   32'(HOLD),    32'(0));
    chk("arst_busoe",  32'(BUS_OE),  32'(0));
    chk("arst_dataoe", 32'(DATA_OE), 32'(0));
    chk("arst_busy",   32'(BUSY),    32'(0));
    chk("arst_wrn",    32'(WR_N),    32'(1));
    exp_q.delete(); done_q.delete(); wait_q.delete();
    err_model = 1'b0;
    @(negedge CLK);
    #2 RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    chk("post_rst_busy", 32'(BUSY), 32'(0));

    // Machine is back in IDLE and runs a clean transfer.
    run_job(20'h00C00, 20'h00D00, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1);
    wait_done("post_rst");

    repeat (3) @(negedge CLK);
    chk("exp_q_left",  32'(exp_q.size()),  32'(0));
    chk("done_q_left", 32'(done_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
